// File: rtl/fpm_pkg.sv
// fpm_pkg: shared widths, FSM state type and hidden-bit helper for the float-multiply front end.
package fpm_pkg;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int EXP_W = 8;
  localparam int CNT_W = 5;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic hidden_bit(input logic [EXP_W-1:0] e);
    return |e;
  endfunction
endpackage

// File: rtl/fpm_seq_mantissa_mult_if.sv
// fpm_seq_mantissa_mult_if: operand/result handshake bundle between producer, multiplier and normalize stage.
interface fpm_seq_mantissa_mult_if;
  import fpm_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic out_valid;
  logic out_ready;
  logic [PROD_W-1:0] product;
  logic [EXP_W-1:0] exp_x;
  logic [EXP_W-1:0] exp_y;
  logic sign_out;
  logic exception;
  modport master (
    output in_valid, x, y, out_ready,
    input in_ready, out_valid, product, exp_x, exp_y, sign_out, exception
  );
  modport slave (
    input in_valid, x, y, out_ready,
    output in_ready, out_valid, product, exp_x, exp_y, sign_out, exception
  );
endinterface

// File: rtl/fpm_shift_add_step.sv
// fpm_shift_add_step: adds the shifted multiplicand for each set bit of the current multiplier slice.
module fpm_shift_add_step
  import fpm_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [PROD_W-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] mplr_i,
  input  logic [PROD_W-1:0]         acc_i,
  output logic [PROD_W-1:0]         acc_o
);
  always_comb begin
    acc_o = acc_i;
    for (int k = 0; k < BITS_PER_CYCLE; k++)
      acc_o = acc_o + (mplr_i[k] ? mcand_i << k : '0);
  end
endmodule

// File: rtl/fpm_seq_mantissa_mult.sv
// fpm_seq_mantissa_mult: iterative shift-add 24x24 significand multiplier with valid/ready handshake.
module fpm_seq_mantissa_mult
  import fpm_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  fpm_seq_mantissa_mult_if.slave bus
);
  localparam int B = BITS_PER_CYCLE;
  localparam int N = MANT_W / B;
  generate
    if (!(B == 1 || B == 2 || B == 3 || B == 4 || B == 6 || B == 8 || B == 12 || B == 24)) begin : g_bad_bpc
      $error("BITS_PER_CYCLE must divide 24 evenly");
    end
  endgenerate
  state_t state_q;
  logic out_valid_q;
  logic [PROD_W-1:0] mcand_q;
  logic [PROD_W-1:0] acc_q;
  logic [PROD_W-1:0] acc_d;
  logic [PROD_W-1:0] product_q;
  logic [MANT_W-1:0] mplr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [EXP_W-1:0] exp_x_q;
  logic [EXP_W-1:0] exp_y_q;
  logic sign_q;
  logic exc_q;
  logic accept;
  logic last;
  logic [MANT_W-1:0] op_x;
  logic [MANT_W-1:0] op_y;
  assign op_x = {hidden_bit(bus.x[30:23]), bus.x[22:0]};
  assign op_y = {hidden_bit(bus.y[30:23]), bus.y[22:0]};
  // rst_n gating keeps in_ready low during reset even though state already reads IDLE
  assign bus.in_ready = rst_n && !flush && (state_q == IDLE || (state_q == DONE && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign last = cnt_q == CNT_W'(N - 1);
  fpm_shift_add_step #(.BITS_PER_CYCLE(B)) u_step (
    .mcand_i(mcand_q),
    .mplr_i (mplr_q[B-1:0]),
    .acc_i  (acc_q),
    .acc_o  (acc_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      mcand_q <= '0;
      mplr_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
      exp_x_q <= '0;
      exp_y_q <= '0;
      sign_q <= 1'b0;
      exc_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      state_q <= BUSY;
      out_valid_q <= 1'b0;
      mcand_q <= {{(PROD_W - MANT_W){1'b0}}, op_x};
      mplr_q <= op_y;
      acc_q <= '0;
      cnt_q <= '0;
      exp_x_q <= bus.x[30:23];
      exp_y_q <= bus.y[30:23];
      sign_q <= bus.x[31] ^ bus.y[31];
      exc_q <= (&bus.x[30:23]) | (&bus.y[30:23]);
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
      mcand_q <= mcand_q << B;
      mplr_q <= mplr_q >> B;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        product_q <= acc_d;
        state_q <= DONE;
        out_valid_q <= 1'b1;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.product = product_q;
  assign bus.exp_x = exp_x_q;
  assign bus.exp_y = exp_y_q;
  assign bus.sign_out = sign_q;
  assign bus.exception = exc_q;
endmodule

// File: tb/tb_fpm_seq_mantissa_mult.sv
// tb_fpm_seq_mantissa_mult: vector table plus scoreboard for the sequential mantissa multiplier.
module tb_fpm_seq_mantissa_mult;
  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [47:0] p;
    logic [7:0] ex;
    logic [7:0] ey;
    logic s;
    logic e;
  } vec_t;
  typedef struct {
    vec_t v;
    int due;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  always #5 clk = ~clk;
  fpm_seq_mantissa_mult_if b1 ();
  fpm_seq_mantissa_mult_if b8 ();
  fpm_seq_mantissa_mult #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1));
  fpm_seq_mantissa_mult #(.BITS_PER_CYCLE(8)) dut8 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b8));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit ov_prev = 0;
  exp_t q[$];
  exp_t mon_e;
  vec_t tv[7];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, want);
    end
  endtask
  // scoreboard: latency on rising out_valid, fields on each transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (b1.out_valid && !ov_prev) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("latency", cyc, q[0].due);
      end
      if (b1.out_valid && b1.out_ready && q.size() > 0) begin
        mon_e = q.pop_front();
        chk("product", b1.product, mon_e.v.p);
        chk("exp_x", b1.exp_x, mon_e.v.ex);
        chk("exp_y", b1.exp_y, mon_e.v.ey);
        chk("sign", b1.sign_out, mon_e.v.s);
        chk("exception", b1.exception, mon_e.v.e);
      end
    end
    ov_prev = b1.out_valid;
  end
  task automatic send(input vec_t v, output int c0);
    bit ok = 0;
    @(posedge clk);
    #1;
    b1.in_valid = 1;
    b1.x = v.x;
    b1.y = v.y;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = b1.in_ready;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      b1.in_valid = 0;
      c0 = -1;
      return;
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    q.push_back('{v, c0 + 24});
    b1.in_valid = 0;
  endtask
  task automatic drain();
    for (int t = 0; t < 200 && q.size() > 0; t++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic quiet(input string n);
    bit seen = 0;
    repeat (30) begin
      @(negedge clk);
      seen |= b1.out_valid;
    end
    chk(n, seen, 0);
  endtask
  task automatic run8(input vec_t v);
    int c0;
    bit ok = 0;
    @(posedge clk);
    #1;
    b8.in_valid = 1;
    b8.x = v.x;
    b8.y = v.y;
    @(negedge clk);
    chk("b8_in_ready", b8.in_ready, 1);
    @(posedge clk);
    #1;
    c0 = cyc;
    b8.in_valid = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = b8.out_valid;
    end
    chk("b8_latency", cyc - c0, 3);
    chk("b8_product", b8.product, v.p);
    chk("b8_exp_x", b8.exp_x, v.ex);
    chk("b8_exp_y", b8.exp_y, v.ey);
    chk("b8_sign", b8.sign_out, v.s);
  endtask
  initial begin
    int c0, c1, c2;
    bit ok;
    tv[0] = '{32'h45800000, 32'h45800000, 48'h400000000000, 8'h8B, 8'h8B, 1'b0, 1'b0};
    tv[1] = '{32'h3FC00000, 32'hC0400000, 48'h900000000000, 8'h7F, 8'h80, 1'b1, 1'b0};
    tv[2] = '{32'h00000001, 32'h3F800000, 48'h000000800000, 8'h00, 8'h7F, 1'b0, 1'b0};
    tv[3] = '{32'h00000000, 32'h00000000, 48'h000000000000, 8'h00, 8'h00, 1'b0, 1'b0};
    tv[4] = '{32'h7F800000, 32'h3F800000, 48'h400000000000, 8'hFF, 8'h7F, 1'b0, 1'b1};
    tv[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 48'hFFFFFE000001, 8'hFF, 8'hFF, 1'b1, 1'b1};
    tv[6] = '{32'hBF800000, 32'h3F800000, 48'h400000000000, 8'h7F, 8'h7F, 1'b1, 1'b0};
    b1.in_valid = 0; b1.x = 0; b1.y = 0; b1.out_ready = 1;
    b8.in_valid = 0; b8.x = 0; b8.y = 0; b8.out_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", b1.in_ready, 0);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_product", b1.product, 0);
    chk("rst_exp", {b1.exp_x, b1.exp_y, b1.sign_out, b1.exception}, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      send(tv[i], c0);
      drain();
    end
    send(tv[1], c0);
    send(tv[2], c1);
    send(tv[3], c2);
    chk("stream_gap0", c1 - c0, 25);
    chk("stream_gap1", c2 - c1, 25);
    drain();
    b1.out_ready = 0;
    send(tv[4], c0);
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = b1.out_valid;
    end
    chk("bp_valid_seen", ok, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      b1.in_valid = 1;
      b1.x = tv[5].x;
      b1.y = tv[5].y;
      @(negedge clk);
      chk("bp_hold_valid", b1.out_valid, 1);
      chk("bp_hold_product", b1.product, tv[4].p);
      chk("bp_hold_exp_x", b1.exp_x, tv[4].ex);
      chk("bp_in_ready", b1.in_ready, 0);
    end
    @(posedge clk);
    #1 b1.out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", b1.in_ready, 1);
    @(posedge clk);
    #1;
    q.push_back('{tv[5], cyc + 24});
    b1.in_valid = 0;
    drain();
    send(tv[0], c0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1;
    b1.in_valid = 1;
    b1.x = tv[1].x;
    b1.y = tv[1].y;
    @(negedge clk);
    chk("flush_in_ready", b1.in_ready, 0);
    @(posedge clk);
    #1;
    flush = 0;
    b1.in_valid = 0;
    q.delete();
    @(negedge clk);
    chk("flush_idle_ready", b1.in_ready, 1);
    quiet("flush_no_valid");
    send(tv[0], c0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    b1.in_valid = 1;
    @(negedge clk);
    chk("rstmid_in_ready", b1.in_ready, 0);
    chk("rstmid_out_valid", b1.out_valid, 0);
    chk("rstmid_product", b1.product, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    b1.in_valid = 0;
    q.delete();
    quiet("rst_no_valid");
    send(tv[2], c0);
    drain();
    run8(tv[1]);
    run8(tv[5]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
